banco_registradores_param: RTL and testbench

BANCO_REGISTRADORES_PARAM -- requirements
Module: banco_registradores_param

---
 rtl/banco_registradores_param_pkg.sv | 17 +
 rtl/banco_registradores_param_placar.sv | 70 +++++++
 rtl/banco_registradores_param.sv | 81 ++++++++
 tb/tb_banco_registradores_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/banco_registradores_param_pkg.sv
// Shared constants and helpers for the parameterised register bank.
package banco_registradores_param_pkg;

    localparam int unsigned LARGURA_PADRAO      = 16;
    localparam int unsigned PROFUNDIDADE_PADRAO = 16;

    // Ceiling log2; valid for the supported depths (2..256).
    function automatic int unsigned log2_teto(input int unsigned valor);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < valor) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/banco_registradores_param_placar.sv
// Reservation scoreboard: one pending-write bit per register plus a running population count.
module placar_reservas
    import banco_registradores_param_pkg::*;
#(
    parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter bit          ZERO_FIXO    = 1'b0,
    localparam int unsigned END         = log2_teto(PROFUNDIDADE)
) (
    input  logic           clk,
    input  logic           ativar_clear,
    input  logic           enable,
    input  logic [END-1:0] endereco_escrita,
    input  logic           reservar,
    input  logic [END-1:0] endereco_reserva,
    input  logic [END-1:0] endereco_reg1,
    input  logic [END-1:0] endereco_reg2,
    output logic           ocupado_reg1,
    output logic           ocupado_reg2,
    output logic [END:0]   num_reservados
);

    localparam logic [END:0] UM = 1;

    logic [PROFUNDIDADE-1:0] bits_q;
    logic [PROFUNDIDADE-1:0] bits_d;
    logic [END:0]            num_q;
    logic [END:0]            num_d;
    logic                    reserva_valida;
    logic                    limpa_valida;
    logic                    incrementa;
    logic                    decrementa;

    always_comb begin
        reserva_valida = reservar && !(ZERO_FIXO && (endereco_reserva == '0));
        // A reservation of the address being written wins, so that write must not clear it.
        limpa_valida   = enable && !(reserva_valida && (endereco_reserva == endereco_escrita));
        incrementa     = reserva_valida && !bits_q[endereco_reserva];
        decrementa     = limpa_valida && bits_q[endereco_escrita];

        bits_d = bits_q;
        if (limpa_valida) begin
            bits_d[endereco_escrita] = 1'b0;
        end
        if (reserva_valida) begin
            bits_d[endereco_reserva] = 1'b1;
        end

        num_d = num_q;
        case ({incrementa, decrementa})
            2'b10:   num_d = num_q + UM;
            2'b01:   num_d = num_q - UM;
            default: num_d = num_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ativar_clear) begin
            bits_q <= '0;
            num_q  <= '0;
        end else begin
            bits_q <= bits_d;
            num_q  <= num_d;
        end
    end

    assign ocupado_reg1   = bits_q[endereco_reg1];
    assign ocupado_reg2   = bits_q[endereco_reg2];
    assign num_reservados = num_q;

endmodule

// File: rtl/banco_registradores_param.sv
// Two-read, one-write register bank with optional write forwarding, hard-wired zero register
// and a reservation scoreboard for pending writes.
module banco_registradores_param
    import banco_registradores_param_pkg::*;
#(
    parameter int unsigned LARGURA      = LARGURA_PADRAO,
    parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter bit          BYPASS       = 1'b1,
    parameter bit          ZERO_FIXO    = 1'b0,
    localparam int unsigned END         = log2_teto(PROFUNDIDADE)
) (
    input  logic               clk,
    input  logic               ativar_clear,
    input  logic               enable,
    input  logic [END-1:0]     endereco_escrita,
    input  logic [LARGURA-1:0] conteudo_escrita,
    input  logic [END-1:0]     endereco_reg1,
    input  logic [END-1:0]     endereco_reg2,
    output logic [LARGURA-1:0] conteudo_reg1,
    output logic [LARGURA-1:0] conteudo_reg2,
    input  logic               reservar,
    input  logic [END-1:0]     endereco_reserva,
    output logic               ocupado_reg1,
    output logic               ocupado_reg2,
    output logic [END:0]       num_reservados
);

    logic [LARGURA-1:0] regs_q [PROFUNDIDADE];
    logic               escrita_valida;

    assign escrita_valida = enable && !(ZERO_FIXO && (endereco_escrita == '0));

    always_ff @(posedge clk) begin
        if (ativar_clear) begin
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                regs_q[i] <= '0;
            end
        end else if (escrita_valida) begin
            regs_q[endereco_escrita] <= conteudo_escrita;
        end
    end

    // Forwarding still applies while clear is asserted; zero register overrides forwarding.
    always_comb begin
        conteudo_reg1 = regs_q[endereco_reg1];
        if (BYPASS && enable && (endereco_escrita == endereco_reg1)) begin
            conteudo_reg1 = conteudo_escrita;
        end
        if (ZERO_FIXO && (endereco_reg1 == '0)) begin
            conteudo_reg1 = '0;
        end
    end

    always_comb begin
        conteudo_reg2 = regs_q[endereco_reg2];
        if (BYPASS && enable && (endereco_escrita == endereco_reg2)) begin
            conteudo_reg2 = conteudo_escrita;
        end
        if (ZERO_FIXO && (endereco_reg2 == '0)) begin
            conteudo_reg2 = '0;
        end
    end

    placar_reservas #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .ZERO_FIXO    (ZERO_FIXO)
    ) u_placar (
        .clk              (clk),
        .ativar_clear     (ativar_clear),
        .enable           (enable),
        .endereco_escrita (endereco_escrita),
        .reservar         (reservar),
        .endereco_reserva (endereco_reserva),
        .endereco_reg1    (endereco_reg1),
        .endereco_reg2    (endereco_reg2),
        .ocupado_reg1     (ocupado_reg1),
        .ocupado_reg2     (ocupado_reg2),
        .num_reservados   (num_reservados)
    );

endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed bench: three bank configurations share one stimulus stream.
module tb_banco_registradores_param;

    logic        clk = 1'b0;
    logic        ativar_clear;
    logic        enable;
    logic [3:0]  endereco_escrita;
    logic [15:0] conteudo_escrita;
    logic [3:0]  endereco_reg1;
    logic [3:0]  endereco_reg2;
    logic        reservar;
    logic [3:0]  endereco_reserva;

    // b1: BYPASS=1/ZERO_FIXO=0, b0: BYPASS=0, z: ZERO_FIXO=1
    logic [15:0] c1_b1, c2_b1, c1_b0, c2_b0, c1_z, c2_z;
    logic        o1_b1, o2_b1, o1_b0, o2_b0, o1_z, o2_z;
    logic [4:0]  n_b1, n_b0, n_z;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    banco_registradores_param #(.LARGURA(16), .PROFUNDIDADE(16), .BYPASS(1'b1), .ZERO_FIXO(1'b0))
    dut_b1 (
        .clk(clk), .ativar_clear(ativar_clear), .enable(enable),
        .endereco_escrita(endereco_escrita), .conteudo_escrita(conteudo_escrita),
        .endereco_reg1(endereco_reg1), .endereco_reg2(endereco_reg2),
        .conteudo_reg1(c1_b1), .conteudo_reg2(c2_b1),
        .reservar(reservar), .endereco_reserva(endereco_reserva),
        .ocupado_reg1(o1_b1), .ocupado_reg2(o2_b1), .num_reservados(n_b1)
    );

    banco_registradores_param #(.LARGURA(16), .PROFUNDIDADE(16), .BYPASS(1'b0), .ZERO_FIXO(1'b0))
    dut_b0 (
        .clk(clk), .ativar_clear(ativar_clear), .enable(enable),
        .endereco_escrita(endereco_escrita), .conteudo_escrita(conteudo_escrita),
        .endereco_reg1(endereco_reg1), .endereco_reg2(endereco_reg2),
        .conteudo_reg1(c1_b0), .conteudo_reg2(c2_b0),
        .reservar(reservar), .endereco_reserva(endereco_reserva),
        .ocupado_reg1(o1_b0), .ocupado_reg2(o2_b0), .num_reservados(n_b0)
    );

    banco_registradores_param #(.LARGURA(16), .PROFUNDIDADE(16), .BYPASS(1'b1), .ZERO_FIXO(1'b1))
    dut_z (
        .clk(clk), .ativar_clear(ativar_clear), .enable(enable),
        .endereco_escrita(endereco_escrita), .conteudo_escrita(conteudo_escrita),
        .endereco_reg1(endereco_reg1), .endereco_reg2(endereco_reg2),
        .conteudo_reg1(c1_z), .conteudo_reg2(c2_z),
        .reservar(reservar), .endereco_reserva(endereco_reserva),
        .ocupado_reg1(o1_z), .ocupado_reg2(o2_z), .num_reservados(n_z)
    );

    typedef struct {
        logic        en;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        res;
        logic [3:0]  ra;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [15:0] c1;
        logic [15:0] c2;
        logic        o1;
        logic        o2;
        logic [4:0]  num;
    } vetor_t;

    vetor_t vetores[15];

    function automatic vetor_t mk(input logic en, input logic [3:0] wa, input logic [15:0] wd,
                                  input logic res, input logic [3:0] ra, input logic [3:0] r1,
                                  input logic [3:0] r2, input logic [15:0] c1,
                                  input logic [15:0] c2, input logic o1, input logic o2,
                                  input logic [4:0] num);
        vetor_t v;
        v.en = en; v.wa = wa; v.wd = wd; v.res = res; v.ra = ra; v.r1 = r1; v.r2 = r2;
        v.c1 = c1; v.c2 = c2; v.o1 = o1; v.o2 = o2; v.num = num;
        return v;
    endfunction

    task automatic chk(input string nome, input logic [15:0] atual, input logic [15:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic drive(input logic clr, input logic en, input logic [3:0] wa,
                         input logic [15:0] wd, input logic res, input logic [3:0] ra,
                         input logic [3:0] r1, input logic [3:0] r2);
        ativar_clear     = clr;
        enable           = en;
        endereco_escrita = wa;
        conteudo_escrita = wd;
        reservar         = res;
        endereco_reserva = ra;
        endereco_reg1    = r1;
        endereco_reg2    = r2;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        vetores[0]  = mk(1, 5, 16'h1234, 0, 0, 5, 3, 16'h1234, 16'h0000, 0, 0, 0);
        vetores[1]  = mk(0, 0, 16'h0000, 0, 0, 5, 5, 16'h1234, 16'h1234, 0, 0, 0);
        vetores[2]  = mk(1, 3, 16'hBEEF, 0, 0, 5, 3, 16'h1234, 16'hBEEF, 0, 0, 0);
        vetores[3]  = mk(0, 0, 16'h0000, 1, 2, 2, 3, 16'h0000, 16'hBEEF, 0, 0, 0);
        vetores[4]  = mk(0, 0, 16'h0000, 1, 7, 2, 7, 16'h0000, 16'h0000, 1, 0, 1);
        vetores[5]  = mk(0, 0, 16'h0000, 1, 9, 7, 9, 16'h0000, 16'h0000, 1, 0, 2);
        vetores[6]  = mk(0, 0, 16'h0000, 0, 0, 9, 2, 16'h0000, 16'h0000, 1, 1, 3);
        vetores[7]  = mk(1, 7, 16'h0777, 0, 0, 7, 9, 16'h0777, 16'h0000, 1, 1, 3);
        vetores[8]  = mk(1, 2, 16'h0222, 1, 4, 7, 2, 16'h0777, 16'h0222, 0, 1, 2);
        vetores[9]  = mk(0, 0, 16'h0000, 0, 0, 4, 2, 16'h0000, 16'h0222, 1, 0, 2);
        vetores[10] = mk(1, 6, 16'h0666, 1, 6, 6, 5, 16'h0666, 16'h1234, 0, 0, 2);
        vetores[11] = mk(0, 0, 16'h0000, 0, 0, 6, 7, 16'h0666, 16'h0777, 1, 0, 3);
        vetores[12] = mk(0, 0, 16'h0000, 1, 9, 9, 6, 16'h0000, 16'h0666, 1, 1, 3);
        vetores[13] = mk(1, 5, 16'h5555, 0, 0, 9, 4, 16'h0000, 16'h0000, 1, 1, 3);
        vetores[14] = mk(0, 0, 16'h0000, 0, 0, 5, 4, 16'h5555, 16'h0000, 0, 1, 3);

        // Clear is asserted from time zero so the first edge already resets.
        drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd15);
        #1;
        chk("reset b1 c1", c1_b1, 16'h0);
        chk("reset b1 c2", c2_b1, 16'h0);
        chk("reset b1 o1", {15'b0, o1_b1}, 16'h0);
        chk("reset b1 o2", {15'b0, o2_b1}, 16'h0);
        chk("reset b1 num", {11'b0, n_b1}, 16'h0);
        chk("reset b0 c1", c1_b0, 16'h0);
        chk("reset z num", {11'b0, n_z}, 16'h0);

        // Write 0x1234 to register 5: no forwarding on b0, forwarding on b1.
        drive(1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 4'd5, 4'd5);
        #1;
        chk("nobypass pre-edge c1", c1_b0, 16'h0000);
        chk("bypass pre-edge c1", c1_b1, 16'h1234);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd5);
        #1;
        chk("nobypass post-edge c1", c1_b0, 16'h1234);

        // Register 0 is hard-wired zero on dut_z, writable on dut_b1.
        drive(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd0);
        #1;
        chk("zero pre-edge c1", c1_z, 16'h0000);
        chk("b1 reg0 bypass c1", c1_b1, 16'hFFFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        #1;
        chk("zero post c1", c1_z, 16'h0000);
        chk("zero post o1", {15'b0, o1_z}, 16'h0);
        chk("zero post num", {11'b0, n_z}, 16'h0);
        chk("b1 reg0 post c1", c1_b1, 16'hFFFF);
        chk("b1 reg0 post o1", {15'b0, o1_b1}, 16'h1);
        chk("b1 reg0 post num", {11'b0, n_b1}, 16'h1);

        do_reset();

        for (int i = 0; i < 15; i++) begin
            drive(1'b0, vetores[i].en, vetores[i].wa, vetores[i].wd, vetores[i].res,
                  vetores[i].ra, vetores[i].r1, vetores[i].r2);
            #1;
            chk($sformatf("vec%0d c1", i), c1_b1, vetores[i].c1);
            chk($sformatf("vec%0d c2", i), c2_b1, vetores[i].c2);
            chk($sformatf("vec%0d o1", i), {15'b0, o1_b1}, {15'b0, vetores[i].o1});
            chk($sformatf("vec%0d o2", i), {15'b0, o2_b1}, {15'b0, vetores[i].o2});
            chk($sformatf("vec%0d num", i), {11'b0, n_b1}, {11'b0, vetores[i].num});
            @(negedge clk);
        end

        // Fill and reserve every register; the count saturates at depth (depth-1 with zero reg).
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(i), 16'hA000 | 16'(i), 1'b1, 4'(i), 4'd0, 4'd0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd15);
        #1;
        chk("full b1 num", {11'b0, n_b1}, 16'd16);
        chk("full b0 num", {11'b0, n_b0}, 16'd16);
        chk("full z num", {11'b0, n_z}, 16'd15);
        chk("full b1 c1", c1_b1, 16'hA000);
        chk("full b1 c2", c2_b1, 16'hA00F);
        chk("full b1 o1", {15'b0, o1_b1}, 16'h1);
        chk("full z c1", c1_z, 16'h0000);
        chk("full z o1", {15'b0, o1_z}, 16'h0);
        chk("full z o2", {15'b0, o2_z}, 16'h1);

        // Clear with write and reserve active: reads still show old contents plus forwarding.
        drive(1'b1, 1'b1, 4'd1, 16'hFFFF, 1'b1, 4'd1, 4'd1, 4'd2);
        #1;
        chk("clear pre b1 c1", c1_b1, 16'hFFFF);
        chk("clear pre b1 c2", c2_b1, 16'hA002);
        chk("clear pre b0 c1", c1_b0, 16'hA001);
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'(a), 4'(15 - a));
            #1;
            chk($sformatf("cleared c1 r%0d", a), c1_b1, 16'h0);
            chk($sformatf("cleared c2 r%0d", 15 - a), c2_b1, 16'h0);
            chk($sformatf("cleared o1 r%0d", a), {15'b0, o1_b1}, 16'h0);
        end
        chk("cleared b1 num", {11'b0, n_b1}, 16'h0);
        chk("cleared z num", {11'b0, n_z}, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
